// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the single-cycle MIPS datapath. It owns the
// fetch PC and issues one word read at a time to instruction memory over a
// req/ack handshake. Returned words are buffered together with their PCs in a
// small FIFO that is presented to the datapath with valid/ready. A redirect
// flushes the FIFO, restarts fetch at the new address and discards any
// response that is still in flight.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   RESET_PC  fetch address after reset (word aligned)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset (0 = reset asserted)
//   imem_req     read request to instruction memory
//   imem_addr    word-aligned byte address of the request
//   imem_ack     request accepted; imem_rdata valid this cycle
//   imem_rdata   instruction word returned with ack
//   instr_valid  FIFO head valid
//   instr        FIFO head instruction
//   instr_pc     FIFO head byte address
//   instr_ready  datapath consumes the head when instr_valid & instr_ready
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address; bits [1:0] ignored
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_consumed  count of instructions handed to the datapath
//   perf_flushed   count of FIFO entries flushed plus discarded responses
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_consumed,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,   // no request outstanding
    REQ,    // live request outstanding
    DRAIN   // stale request outstanding after a redirect
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  entry_t           store [DEPTH];
  entry_t           head;
  entry_t           push_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic             discard;
  logic [31:0]      target;
  logic             unused_low_bits;

  assign target          = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  // Redirect overrides both ends of the FIFO: nothing is pushed or consumed
  // in the cycle a redirect is sampled.
  assign pop        = instr_valid & instr_ready & ~redirect;
  assign push       = (state == REQ) & imem_ack & ~redirect;
  assign discard    = imem_ack & (((state == REQ) & redirect) | (state == DRAIN));
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign push_entry = '{pc: fetch_pc, word: imem_rdata};

  assign instr_valid = (count != '0);
  assign instr       = head.word;
  assign instr_pc    = head.pc;

  // ---------------------------------------------------------------------------
  // Fetch FSM. imem_req/imem_addr are registered so they stay stable for the
  // whole life of a request. The in-flight request counts toward occupancy,
  // so a new request is only issued when its word is guaranteed a FIFO slot.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
      if (state == IDLE || imem_ack) begin
        // Nothing left in flight: restart from the new address next cycle.
        state     <= IDLE;
        imem_req  <= 1'b0;
        imem_addr <= target;
      end else begin
        // Request still pending: keep it stable and throw its data away.
        state <= DRAIN;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < CNT_W'(DEPTH)) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc  <= fetch_pc + 32'd4;
            imem_addr <= fetch_pc + 32'd4;
            if (count_next < CNT_W'(DEPTH)) begin
              state <= REQ;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control. The head is kept in its own register so the outputs hold
  // the last delivered entry when the FIFO runs empty or is flushed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      count <= count_next;
      if (count_next != '0) begin
        // The pushed word becomes the head when it lands in an empty FIFO,
        // including the case where the only entry is popped this cycle.
        if (count == '0 || (pop && count == CNT_W'(1))) begin
          head <= push_entry;
        end else if (pop) begin
          head <= store[rd_ptr_nxt];
        end
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is defined by
  // the pointers and count alone, so resetting the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_entry;
  end

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters; both wrap naturally at 2^32.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_consumed <= '0;
      perf_flushed  <= '0;
    end else begin
      if (pop) perf_consumed <= perf_consumed + 32'd1;
      perf_flushed <= perf_flushed
                    + (redirect ? 32'(count) : 32'd0)
                    + 32'(discard);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Instruction memory is modelled as a
// pure function of the address; the expected instruction stream is derived
// from the fetch rules (sequential PCs restarting at each redirect target).
// A second instance with a high RESET_PC covers address wrap and async reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main instance (RESET_PC = 0)
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_consumed;
  logic [31:0] perf_flushed;
`endif

  // Wrap instance (RESET_PC near the top of the address space)
  logic        reset_w;
  logic        req_w;
  logic [31:0] addr_w;
  logic        ack_w;
  logic [31:0] rdata_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;
  logic        ready_w;
  logic        redirect_w;
  logic [31:0] redirect_pc_w;
`ifdef FETCH_PERF_EN
  logic [31:0] unused_perf_consumed_w;
  logic [31:0] unused_perf_flushed_w;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign rdata_w    = mem_word(addr_w);

  fetch_unit #(.DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_consumed (perf_consumed),
    .perf_flushed  (perf_flushed)
`endif
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_dut_wrap (
    .clk         (clk),
    .reset       (reset_w),
    .imem_req    (req_w),
    .imem_addr   (addr_w),
    .imem_ack    (ack_w),
    .imem_rdata  (rdata_w),
    .instr_valid (valid_w),
    .instr       (instr_w),
    .instr_pc    (pc_w),
    .instr_ready (ready_w),
    .redirect    (redirect_w),
    .redirect_pc (redirect_pc_w)
`ifdef FETCH_PERF_EN
    ,
    .perf_consumed (unused_perf_consumed_w),
    .perf_flushed  (unused_perf_flushed_w)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and releases it 1ns after a rising edge.
  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_w = 1'b1;
    imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ack_w = 1'b0; ready_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0;
    #2;
    reset = 1'b0; reset_w = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    n_tests++; if (addr_w !== WRAP_PC) begin n_fail++; $display("FAIL reset_addr_wrap: got %h expected %h", addr_w, WRAP_PC); end
    imem_ack = 1'b1; instr_ready = 1'b1;
    repeat (3) cycle();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req: got %b expected 0", imem_req); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b expected 0", instr_valid); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_consumed !== 32'h0) begin n_fail++; $display("FAIL reset_perf_consumed: got %0d expected 0", perf_consumed); end
    n_tests++; if (perf_flushed !== 32'h0) begin n_fail++; $display("FAIL reset_perf_flushed: got %0d expected 0", perf_flushed); end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    imem_ack = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    apply_reset();
    cycle();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b expected 0", instr_valid); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      exp = 32'(4 * k);
      n_tests++; if ({instr_valid, instr_pc} !== {1'b1, exp}) begin n_fail++; $display("FAIL stream_pc: got valid=%b pc=%h expected valid=1 pc=%h", instr_valid, instr_pc, exp); end
      n_tests++; if (instr !== mem_word(exp)) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", instr, mem_word(exp)); end
    end
  endtask

  task automatic test_backpressure();
    int n_hs = 0;
    int got = 0;
    logic [31:0] exp = 32'h0;
    imem_ack = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (imem_req && imem_ack) n_hs++;
      cycle();
    end
    n_tests++; if (n_hs !== DEPTH) begin n_fail++; $display("FAIL bp_push_count: got %0d expected %0d", n_hs, DEPTH); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stop: got %b expected 0", imem_req); end
    n_tests++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    for (int c = 0; c < 40 && got < 12; c++) begin
      if (instr_valid) begin
        n_tests++; if (instr_pc !== exp || instr !== mem_word(exp)) begin n_fail++; $display("FAIL bp_resume: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, exp, mem_word(exp)); end
        exp += 32'd4;
        got++;
      end
      cycle();
    end
    n_tests++; if (got !== 12) begin n_fail++; $display("FAIL bp_resume_count: got %0d expected 12", got); end
  endtask

  task automatic test_ack_delay();
    imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    apply_reset();
    cycle();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL delay_req0: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    for (int c = 1; c < 4; c++) begin
      cycle();
      n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL delay_stable: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    end
    imem_ack = 1'b1;
    cycle();
    imem_ack = 1'b0;
    n_tests++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL delay_push: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
    n_tests++; if (instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL delay_instr: got %h expected %h", instr, mem_word(32'h0)); end
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL delay_next_req: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr); end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL delay_single_push: got valid=%b expected 0", instr_valid); end
  endtask

  task automatic test_redirect_drain();
    imem_ack = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    apply_reset();
    repeat (3) cycle();
    imem_ack = 1'b0;
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL drain_pre: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got valid=%b expected 0", instr_valid); end
    for (int c = 0; c < 3; c++) begin
      n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL drain_hold: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
      if (c < 2) cycle();
    end
    imem_ack = 1'b1;
    cycle();
    imem_ack = 1'b0;
    n_tests++; if ({imem_req, instr_valid} !== 2'b00) begin n_fail++; $display("FAIL drain_done: got req=%b valid=%b expected req=0 valid=0", imem_req, instr_valid); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_flushed !== 32'd3) begin n_fail++; $display("FAIL drain_perf_flushed: got %0d expected 3", perf_flushed); end
`endif
    cycle();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL drain_new_req: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr); end
    imem_ack = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 10 && !instr_valid; c++) cycle();
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL drain_timeout: got valid=%b expected 1", instr_valid); end
    n_tests++; if (instr_pc !== 32'h40 || instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL drain_first: got pc=%h instr=%h expected pc=00000040 instr=%h", instr_pc, instr, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    apply_reset();
    repeat (4) cycle();
    n_tests++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'hC, 1'b1}) begin n_fail++; $display("FAIL rack_pre: got req=%b addr=%h valid=%b expected req=1 addr=0000000c valid=1", imem_req, imem_addr, instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h103;
    cycle();
    redirect = 1'b0;
    n_tests++; if ({instr_valid, imem_req} !== 2'b00) begin n_fail++; $display("FAIL rack_flush: got valid=%b req=%b expected valid=0 req=0", instr_valid, imem_req); end
    n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rack_addr: got %h expected 00000100", imem_addr); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_flushed !== 32'd4) begin n_fail++; $display("FAIL rack_perf_flushed: got %0d expected 4", perf_flushed); end
    n_tests++; if (perf_consumed !== 32'd0) begin n_fail++; $display("FAIL rack_perf_consumed: got %0d expected 0", perf_consumed); end
`endif
    cycle();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL rack_new_req: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    instr_ready = 1'b1;
    for (int c = 0; c < 10 && !instr_valid; c++) cycle();
    n_tests++; if ({instr_valid, instr_pc} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL rack_first: got valid=%b pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] exp_seq [3];
    int got = 0;
    exp_seq = '{WRAP_PC, WRAP_PC + 32'd4, 32'h0};
    ack_w = 1'b1; ready_w = 1'b1; redirect_w = 1'b0;
    @(posedge clk);
    #1;
    reset_w = 1'b1;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (valid_w && ready_w) begin
        n_tests++; if (pc_w !== exp_seq[got] || instr_w !== mem_word(exp_seq[got])) begin n_fail++; $display("FAIL wrap_pc: got pc=%h instr=%h expected pc=%h instr=%h", pc_w, instr_w, exp_seq[got], mem_word(exp_seq[got])); end
        got++;
      end
      cycle();
    end
    n_tests++; if (got !== 3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", got); end
    n_tests++; if ({req_w, valid_w} !== 2'b11) begin n_fail++; $display("FAIL wrap_streaming: got req=%b valid=%b expected req=1 valid=1", req_w, valid_w); end
    #2;
    reset_w = 1'b0;
    #1;
    n_tests++; if ({req_w, valid_w} !== 2'b00) begin n_fail++; $display("FAIL async_reset: got req=%b valid=%b expected req=0 valid=0", req_w, valid_w); end
    n_tests++; if (addr_w !== WRAP_PC) begin n_fail++; $display("FAIL async_reset_addr: got %h expected %h", addr_w, WRAP_PC); end
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_req;
    logic        prev_ack;
    logic        prev_redirect;
    int          n_pop;
    int          n_ack;
    imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    apply_reset();
    exp_pc = 32'h0; prev_addr = 32'h0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_redirect = 1'b0;
    n_pop = 0; n_ack = 0;
    for (int c = 0; c < 2000; c++) begin
      if (prev_redirect) begin
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush: got valid=%b expected 0 (cycle %0d)", instr_valid, c); end
      end
      if (prev_req && !prev_ack) begin
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin n_fail++; $display("FAIL rnd_req_hold: got req=%b addr=%h expected req=1 addr=%h (cycle %0d)", imem_req, imem_addr, prev_addr, c); end
      end
      if (imem_req) begin
        n_tests++; if (imem_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align: got addr=%h expected low bits 00", imem_addr); end
      end
      imem_ack    = ($urandom_range(0, 2) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (instr_valid && instr_ready) begin
        n_tests++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_stream: got pc=%h instr=%h expected pc=%h instr=%h (cycle %0d)", instr_pc, instr, exp_pc, mem_word(exp_pc), c); end
        exp_pc += 32'd4;
        n_pop++;
      end
      if (imem_req && imem_ack) n_ack++;
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr; prev_redirect = redirect;
      cycle();
    end
    imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      if (instr_valid) begin
        n_tests++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_drain: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 32'd4;
        n_pop++;
      end
      cycle();
    end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty: got valid=%b expected 0", instr_valid); end
    n_tests++; if (n_pop < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d pops expected at least 100", n_pop); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_consumed !== 32'(n_pop)) begin n_fail++; $display("FAIL rnd_perf_consumed: got %0d expected %0d", perf_consumed, n_pop); end
    n_tests++; if (perf_flushed !== 32'(n_ack - n_pop)) begin n_fail++; $display("FAIL rnd_perf_flushed: got %0d expected %0d", perf_flushed, n_ack - n_pop); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ack_delay();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the single-cycle MIPS datapath.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to the datapath with valid/ready.
- Supports redirect (branch/jump) with flush, including discarding a response still in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  byte address of request; always word aligned
- imem_ack  in  1  request accepted; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word returned with ack
- instr_valid  out  1  FIFO head valid
- instr  out  32  FIFO head instruction
- instr_pc  out  32  FIFO head byte address
- instr_ready  in  1  datapath consumes head when instr_valid & instr_ready
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, state IDLE. imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DRAIN: stale request outstanding after a redirect.
- imem_addr = fetch_pc in IDLE/REQ; in DRAIN = stale address (held).
- Issue rule: imem_req=1 in REQ/DRAIN; IDLE→REQ when occupancy < DEPTH and no redirect this cycle.
- At most one request outstanding. imem_req and imem_addr are held stable until imem_ack; ack is only meaningful while imem_req=1.
- Occupancy counts FIFO entries plus the outstanding request, so an acked word never finds the FIFO full.
- Ack in REQ (no redirect):
  - push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping 32'hFFFF_FFFC→0.
  - Go to IDLE, or stay in REQ if occupancy after push and pop < DEPTH (back-to-back issue allowed).
- Latency: first request asserted the cycle after reset deasserts; with same-cycle ack, instr_valid=1 the following cycle. Sustained throughput 1 instr/cycle with 0-wait memory.
- Head outputs: combinational from FIFO head register (registered storage). instr/instr_pc hold their last value when empty; only instr_valid is qualified.
- Pop: instr_valid & instr_ready; push and pop in the same cycle are both honoured; occupancy unchanged.
- Redirect (highest priority), on the cycle it is sampled:
  - Flush FIFO; no pop counted; instr_valid=0 next cycle.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - If in REQ without ack: go to DRAIN.
  - If ack in the same cycle: discard rdata, go to IDLE.
  - If in IDLE: go to IDLE; the new request issues the next cycle.
- DRAIN: wait for ack, discard data, go to IDLE. A further redirect in DRAIN updates fetch_pc only.
- Simultaneous redirect and instr_ready: redirect wins; no consume.
- Reset mid-operation: all state cleared immediately; the outstanding request is abandoned.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_consumed[31:0] and perf_flushed[31:0].
  - perf_consumed increments per pop.
  - perf_flushed adds the number of FIFO entries flushed plus 1 per discarded in-flight response.
  - Both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ack tied 1, instr_ready=1, rdata=addr-based pattern → pcs 0,4,8,12 on consecutive cycles, first instr_valid 2 cycles after reset rises.
- instr_ready=0, ack=1 → exactly 4 pushes (pc 0..12), then imem_req=0. Set ready=1 → pcs stream resume at 16 with no gap or duplicate.
- Ack delayed 3 cycles → imem_req and imem_addr stable for all 4 cycles, single push.
- Redirect to 0x40 while a request to 0x08 is pending without ack → DRAIN. Ack later, its data not delivered; next request addr=0x40; first valid instr_pc=0x40.
- Redirect to 0x103 while FIFO holds 3 entries and ack arrives in the same cycle → FIFO empty next cycle, rdata dropped, next imem_addr=0x100. With FETCH_PERF_EN, perf_flushed=4.
- RESET_PC=32'hFFFF_FFF8, ack=1 → instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert reset mid-stream → imem_req=0, instr_valid=0 asynchronously.
